// File: rtl/secure_router_deser_pkg.sv
// Shared constants for the secure router per-port serial receiver:
// FSM state encodings, error codes and the default decryption key.
package secure_router_deser_pkg;

  localparam int DEFAULT_DATA_W = 4;
  localparam int DEFAULT_GAP_MAX = 8;
  localparam logic [DEFAULT_DATA_W-1:0] DEFAULT_KEY = 4'b1010;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RECV = 1'b1
  } state_e;

  typedef enum logic [1:0] {
    ERR_NONE    = 2'b00,
    ERR_PARITY  = 2'b01,
    ERR_TIMEOUT = 2'b10
  } err_e;

endpackage

// File: rtl/secure_router_deser_if.sv
// Serial-in / parallel-out bundle between a router port and its receiver.
// master drives the strobed serial stream, slave is the deserialiser.
interface secure_router_deser_if #(
  parameter int DATA_W = 4
);

  logic              data_in;
  logic              strobe_in;
  logic [DATA_W-1:0] data_out;
  logic              valid_out;
  logic              err_out;
  logic [1:0]        err_type;
  logic [7:0]        frame_cnt;
  logic              busy;

  modport master (
    output data_in, strobe_in,
    input  data_out, valid_out, err_out, err_type, frame_cnt, busy
  );

  modport slave (
    input  data_in, strobe_in,
    output data_out, valid_out, err_out, err_type, frame_cnt, busy
  );

endinterface

// File: rtl/secure_router_deser.sv
// Per-port receiver: collects an MSB-first strobed frame plus even parity bit,
// decrypts good frames by XOR with KEY, and flags parity or gap-timeout errors.
module secure_router_deser
  import secure_router_deser_pkg::*;
#(
  parameter int                DATA_W  = DEFAULT_DATA_W,
  parameter logic [DATA_W-1:0] KEY     = DEFAULT_KEY,
  parameter int                GAP_MAX = DEFAULT_GAP_MAX
) (
  input logic                  clk,
  input logic                  rst,
  secure_router_deser_if.slave bus
);

  localparam int CNT_W = $clog2(DATA_W + 1);
  localparam int GAP_W = $clog2(GAP_MAX + 1);

  state_e            state_q, state_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic [GAP_W-1:0]  gap_cnt_q, gap_cnt_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              valid_q, valid_d;
  logic              err_q, err_d;
  err_e              err_type_q, err_type_d;
  logic [7:0]        frame_cnt_q, frame_cnt_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      shift_q     <= '0;
      bit_cnt_q   <= '0;
      gap_cnt_q   <= '0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      err_q       <= 1'b0;
      err_type_q  <= ERR_NONE;
      frame_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      shift_q     <= shift_d;
      bit_cnt_q   <= bit_cnt_d;
      gap_cnt_q   <= gap_cnt_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      err_q       <= err_d;
      err_type_q  <= err_type_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    shift_d     = shift_q;
    bit_cnt_d   = bit_cnt_q;
    gap_cnt_d   = gap_cnt_q;
    data_d      = data_q;
    valid_d     = 1'b0;
    err_d       = 1'b0;
    err_type_d  = err_type_q;
    frame_cnt_d = frame_cnt_q;

    case (state_q)
      ST_IDLE: begin
        if (bus.strobe_in) begin
          shift_d   = {shift_q[DATA_W-2:0], bus.data_in};
          bit_cnt_d = CNT_W'(1);
          gap_cnt_d = '0;
          state_d   = ST_RECV;
        end
      end
      ST_RECV: begin
        if (bus.strobe_in) begin
          gap_cnt_d = '0;
          // The (DATA_W+1)th strobed bit is parity over the ciphertext.
          if (bit_cnt_q == CNT_W'(DATA_W)) begin
            state_d = ST_IDLE;
            if ((^shift_q ^ bus.data_in) == 1'b0) begin
              data_d      = shift_q ^ KEY;
              valid_d     = 1'b1;
              frame_cnt_d = frame_cnt_q + 8'd1;
            end else begin
              err_d      = 1'b1;
              err_type_d = ERR_PARITY;
            end
          end else begin
            shift_d   = {shift_q[DATA_W-2:0], bus.data_in};
            bit_cnt_d = bit_cnt_q + CNT_W'(1);
          end
        end else if (gap_cnt_q == GAP_W'(GAP_MAX - 1)) begin
          err_d      = 1'b1;
          err_type_d = ERR_TIMEOUT;
          state_d    = ST_IDLE;
        end else begin
          gap_cnt_d = gap_cnt_q + GAP_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign bus.data_out  = data_q;
  assign bus.valid_out = valid_q;
  assign bus.err_out   = err_q;
  assign bus.err_type  = err_type_q;
  assign bus.frame_cnt = frame_cnt_q;
  assign bus.busy      = (state_q == ST_RECV);

endmodule

// File: tb/tb_secure_router_deser.sv
// Bench for secure_router_deser: hand-computed vector table, hand-written
// corner sequences, then random traffic checked against a frame-level model.
module tb_secure_router_deser;

  localparam int         DATA_W  = 4;
  localparam int         GAP_MAX = 8;
  localparam logic [3:0] KEY     = 4'b1010;

  logic clk = 1'b0;
  logic rst = 1'b1;

  secure_router_deser_if #(.DATA_W(DATA_W)) bus ();

  secure_router_deser #(
    .DATA_W (DATA_W),
    .KEY    (KEY),
    .GAP_MAX(GAP_MAX)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passed = 0;

  // Frame-level reference: bits collected in a queue, decoded when complete.
  bit         bits[$];
  bit         inFrame = 1'b0;
  int         gapRun = 0;
  logic [3:0] mData = '0;
  logic       mValid = 1'b0;
  logic       mErr = 1'b0;
  logic [1:0] mType = 2'b00;
  logic [7:0] mCnt = '0;
  bit         modelCheck = 1'b1;

  typedef struct {
    string      name;
    string      seq;
    logic [3:0] expData;
    logic       expValid;
    logic       expErr;
    logic [1:0] expType;
    logic [7:0] expCnt;
    logic       expBusy;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [16:0] observed();
    return {bus.busy, bus.frame_cnt, bus.err_type, bus.err_out, bus.valid_out, bus.data_out};
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  task automatic modelStep(input bit d, input bit s, input bit r);
    int ones;
    logic [3:0] payload;
    mValid = 1'b0;
    mErr   = 1'b0;
    if (r) begin
      bits.delete();
      inFrame = 1'b0;
      gapRun = 0;
      mData = '0;
      mType = 2'b00;
      mCnt = '0;
    end else if (s) begin
      inFrame = 1'b1;
      gapRun = 0;
      bits.push_back(d);
      if (bits.size() == DATA_W + 1) begin
        ones = 0;
        payload = '0;
        foreach (bits[i]) ones += int'(bits[i]);
        for (int i = 0; i < DATA_W; i++) payload = {payload[2:0], bits[i]};
        if (ones % 2 == 0) begin
          mData = payload ^ KEY;
          mValid = 1'b1;
          mCnt = mCnt + 8'd1;
        end else begin
          mErr = 1'b1;
          mType = 2'b01;
        end
        bits.delete();
        inFrame = 1'b0;
      end
    end else if (inFrame) begin
      gapRun++;
      if (gapRun == GAP_MAX) begin
        mErr = 1'b1;
        mType = 2'b10;
        bits.delete();
        inFrame = 1'b0;
      end
    end
  endtask

  task automatic applyStimulus(input bit d, input bit s, input bit r);
    bus.data_in   = d;
    bus.strobe_in = s;
    rst           = r;
    @(posedge clk);
    #1;
    modelStep(d, s, r);
    if (modelCheck)
      checkOutput("model", 32'(observed()),
                  32'({inFrame, mCnt, mType, mErr, mValid, mData}));
  endtask

  task automatic applySeq(input string seq);
    for (int i = 0; i < seq.len(); i++) begin
      if (seq[i] == "-") applyStimulus(1'b0, 1'b0, 1'b0);
      else applyStimulus(seq[i] == "1", 1'b1, 1'b0);
    end
  endtask

  task automatic goodFrame(input logic [3:0] ct);
    for (int i = 3; i >= 0; i--) applyStimulus(ct[i], 1'b1, 1'b0);
    applyStimulus(^ct, 1'b1, 1'b0);
  endtask

  initial begin
    int dens;
    bus.data_in   = 1'b0;
    bus.strobe_in = 1'b0;

    vecs.push_back('{"good_0110",    "01100",        4'b1100, 1, 0, 2'b00, 8'd1, 0});
    vecs.push_back('{"parity_err",   "01101",        4'b1100, 0, 1, 2'b01, 8'd1, 0});
    vecs.push_back('{"short_gap",    "10---111",     4'b0001, 1, 0, 2'b01, 8'd2, 0});
    vecs.push_back('{"timeout",      "10--------",   4'b0001, 0, 1, 2'b10, 8'd2, 0});
    vecs.push_back('{"after_tmo",    "11000",        4'b0110, 1, 0, 2'b10, 8'd3, 0});
    vecs.push_back('{"idle",         "--",           4'b0110, 0, 0, 2'b10, 8'd3, 0});
    vecs.push_back('{"partial_busy", "101",          4'b0110, 0, 0, 2'b10, 8'd3, 1});
    vecs.push_back('{"finish",       "11",           4'b0001, 1, 0, 2'b10, 8'd4, 0});
    vecs.push_back('{"gap_max_m1",   "0-------0011", 4'b1011, 1, 0, 2'b10, 8'd5, 0});

    applyStimulus(1'b0, 1'b0, 1'b1);
    checkOutput("reset_state", 32'(observed()), 32'h0);

    foreach (vecs[i]) begin
      applySeq(vecs[i].seq);
      checkOutput(vecs[i].name, 32'(observed()),
                  32'({vecs[i].expBusy, vecs[i].expCnt, vecs[i].expType,
                       vecs[i].expErr, vecs[i].expValid, vecs[i].expData}));
    end

    // Back-to-back frames: valid one cycle after each parity bit, none between.
    applySeq("00000");
    checkOutput("b2b_first_valid", 32'({bus.valid_out, bus.data_out}), 32'h1a);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 1'b1, 1'b0);
      checkOutput("b2b_no_valid", 32'({bus.valid_out, bus.busy}), 32'h1);
    end
    applyStimulus(1'b0, 1'b1, 1'b0);
    checkOutput("b2b_second_valid", 32'({bus.valid_out, bus.data_out}), 32'h15);
    checkOutput("b2b_cnt", 32'(bus.frame_cnt), 32'd7);

    // Reset mid-frame discards the partial frame without reporting an error.
    applySeq("10");
    applyStimulus(1'b0, 1'b0, 1'b1);
    checkOutput("mid_reset", 32'(observed()), 32'h0);
    applySeq("-");
    checkOutput("mid_reset_quiet", 32'(observed()), 32'h0);

    for (int f = 0; f < 256; f++) begin
      goodFrame(4'($urandom));
      if (f == 254) checkOutput("cnt_255", 32'(bus.frame_cnt), 32'd255);
    end
    checkOutput("cnt_wrap", 32'({bus.valid_out, bus.frame_cnt}), 32'h100);

    for (int blk = 0; blk < 40; blk++) begin
      case ($urandom_range(0, 2))
        0: dens = 90;
        1: dens = 50;
        default: dens = 12;
      endcase
      for (int c = 0; c < 64; c++)
        applyStimulus(1'($urandom), $urandom_range(0, 99) < dens,
                      $urandom_range(0, 499) == 0);
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
